student_fir_stereo_sched: RTL and testbench

Scheduler that time-shares one channel-aware FIR datapath between the left and right audio channels.
- Per frame, captures the L/R sample pair from the IIS handler on its valid strobe.
- Issues L, then R, to the FIR, tagging each with a channel select; the FIR keeps one history per channel.
- Collects both FIR results and presents them to the IIS handler as one stereo output with a single strobe.
- Sits between the IIS handler's Data_O/valid_strobe and Data_I/valid_strobe_I ports and the FIR's sample/strobe ports.

---
 rtl/student_fir_stereo_sched_if.sv | 44 ++++
 rtl/student_fir_stereo_sched.sv | 99 +++++++++
 tb/tb_student_fir_stereo_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/student_fir_stereo_sched_if.sv
// student_fir_stereo_sched_if: IIS-side and FIR-side signals of the stereo FIR scheduler.
// Stats ports exist only when STUDENT_FIR_SCHED_STATS_EN is defined.
interface student_fir_stereo_sched_if #(
    parameter int DATA_SIZE         = 16,
    parameter int DATA_SIZE_FIR_OUT = 24
);
    logic                         valid_strobe_i;
    logic [DATA_SIZE-1:0]         sample_l_i;
    logic [DATA_SIZE-1:0]         sample_r_i;
    logic                         fir_valid_strobe_o;
    logic [DATA_SIZE-1:0]         fir_sample_o;
    logic                         fir_ch_o;
    logic                         fir_valid_strobe_i;
    logic [DATA_SIZE_FIR_OUT-1:0] fir_y_i;
    logic                         valid_strobe_o;
    logic [DATA_SIZE_FIR_OUT-1:0] y_l_o;
    logic [DATA_SIZE_FIR_OUT-1:0] y_r_o;
    logic                         busy_o;
    logic                         overrun_o;
    logic                         timeout_o;
    logic                         clear_i;
`ifdef STUDENT_FIR_SCHED_STATS_EN
    logic [15:0]                  frame_cnt_o;
    logic [15:0]                  drop_cnt_o;
`endif

    modport slave (
        input  valid_strobe_i, sample_l_i, sample_r_i, fir_valid_strobe_i, fir_y_i, clear_i,
        output fir_valid_strobe_o, fir_sample_o, fir_ch_o, valid_strobe_o, y_l_o, y_r_o,
               busy_o, overrun_o, timeout_o
`ifdef STUDENT_FIR_SCHED_STATS_EN
        , output frame_cnt_o, drop_cnt_o
`endif
    );

    modport master (
        output valid_strobe_i, sample_l_i, sample_r_i, fir_valid_strobe_i, fir_y_i, clear_i,
        input  fir_valid_strobe_o, fir_sample_o, fir_ch_o, valid_strobe_o, y_l_o, y_r_o,
               busy_o, overrun_o, timeout_o
`ifdef STUDENT_FIR_SCHED_STATS_EN
        , input frame_cnt_o, drop_cnt_o
`endif
    );
endinterface

// File: rtl/student_fir_stereo_sched.sv
// student_fir_stereo_sched: time-shares one channel-aware FIR between L and R per stereo frame.
// Optional frame/drop counters are enabled by STUDENT_FIR_SCHED_STATS_EN.
module student_fir_stereo_sched #(
    parameter int DATA_SIZE         = 16,
    parameter int DATA_SIZE_FIR_OUT = 24,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input logic clk_i,
    input logic rst_i,
    student_fir_stereo_sched_if.slave bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE_L, WAIT_L, ISSUE_R, WAIT_R, OUTPUT} state_t;

    state_t                       state, state_nx;
    logic [DATA_SIZE-1:0]         l_q, r_q;
    logic [DATA_SIZE_FIR_OUT-1:0] acc_l, y_l, y_r;
    logic [CW-1:0]                cnt;
    logic                         overrun, timeout;
    logic                         waiting, resp, expire, done, capture, drop, ch;

    always_comb begin
        state_nx = state;
        waiting  = state == WAIT_L || state == WAIT_R;
        resp     = waiting && bus.fir_valid_strobe_i;
        expire   = waiting && !resp && cnt == LAST;
        done     = resp || expire;
        capture  = bus.valid_strobe_i && (state == IDLE || state == OUTPUT);
        drop     = bus.valid_strobe_i && !capture;
        ch       = state == ISSUE_R || state == WAIT_R;
        case (state)
            IDLE:    state_nx = capture ? ISSUE_L : IDLE;
            ISSUE_L: state_nx = WAIT_L;
            WAIT_L:  state_nx = done ? ISSUE_R : WAIT_L;
            ISSUE_R: state_nx = WAIT_R;
            WAIT_R:  state_nx = done ? OUTPUT : WAIT_R;
            OUTPUT:  state_nx = capture ? ISSUE_L : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            acc_l   <= '0;
            y_l     <= '0;
            y_r     <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_nx;
            if (capture) begin
                l_q <= bus.sample_l_i;
                r_q <= bus.sample_r_i;
            end
            cnt <= (state == ISSUE_L || state == ISSUE_R) ? '0 : (waiting && !done) ? cnt + 1'b1 : cnt;
            if (state == WAIT_L && done)
                acc_l <= resp ? bus.fir_y_i : '0;
            // R result goes straight to the output register on the edge leaving WAIT_R
            if (state == WAIT_R && done) begin
                y_l <= acc_l;
                y_r <= resp ? bus.fir_y_i : '0;
            end
            overrun <= drop ? 1'b1 : bus.clear_i ? 1'b0 : overrun;
            timeout <= expire ? 1'b1 : bus.clear_i ? 1'b0 : timeout;
        end
    end

`ifdef STUDENT_FIR_SCHED_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            frame_cnt <= frame_cnt + {15'd0, state == OUTPUT};
            drop_cnt  <= drop_cnt + {15'd0, drop};
        end
    end
    assign bus.frame_cnt_o = frame_cnt;
    assign bus.drop_cnt_o  = drop_cnt;
`endif

    // Combinational outputs are forced low while reset is asserted
    assign bus.fir_valid_strobe_o = !rst_i && (state == ISSUE_L || state == ISSUE_R);
    assign bus.fir_ch_o           = !rst_i && ch;
    assign bus.fir_sample_o       = rst_i ? '0 : ch ? r_q : l_q;
    assign bus.valid_strobe_o     = !rst_i && state == OUTPUT;
    assign bus.busy_o             = !rst_i && state != IDLE;
    assign bus.y_l_o              = y_l;
    assign bus.y_r_o              = y_r;
    assign bus.overrun_o          = overrun;
    assign bus.timeout_o          = timeout;
endmodule

// File: tb/tb_student_fir_stereo_sched.sv
// tb_student_fir_stereo_sched: directed cycle-accurate checks of the stereo FIR scheduler.
module tb_student_fir_stereo_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   seen;

    always #5 clk = ~clk;

    student_fir_stereo_sched_if #(.DATA_SIZE(16), .DATA_SIZE_FIR_OUT(24)) bus ();

    student_fir_stereo_sched #(.DATA_SIZE(16), .DATA_SIZE_FIR_OUT(24), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [15:0] l, input logic [15:0] r);
        bus.valid_strobe_i = 1'b1;
        bus.sample_l_i     = l;
        bus.sample_r_i     = r;
        tick();
        bus.valid_strobe_i = 1'b0;
    endtask

    task automatic respond(input logic [23:0] y);
        bus.fir_valid_strobe_i = 1'b1;
        bus.fir_y_i            = y;
        tick();
        bus.fir_valid_strobe_i = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r, input bit drop);
        start(l, r);
        tick();
        if (drop) bus.valid_strobe_i = 1'b1;
        tick();
        bus.valid_strobe_i = 1'b0;
        tick();
        respond({8'h00, l});
        ticks(3);
        respond({8'h00, r});
        chk("frm_valid", 32'(bus.valid_strobe_o), 32'd1);
        chk("frm_y_l", 32'(bus.y_l_o), {16'h0, l});
        chk("frm_y_r", 32'(bus.y_r_o), {16'h0, r});
        tick();
    endtask

    initial begin
        bus.valid_strobe_i     = 1'b0;
        bus.sample_l_i         = '0;
        bus.sample_r_i         = '0;
        bus.fir_valid_strobe_i = 1'b0;
        bus.fir_y_i            = '0;
        bus.clear_i            = 1'b0;
        ticks(2);
        chk("rst_fir_vs", 32'(bus.fir_valid_strobe_o), 32'd0);
        chk("rst_fir_ch", 32'(bus.fir_ch_o), 32'd0);
        chk("rst_fir_sample", 32'(bus.fir_sample_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_strobe_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_y_l", 32'(bus.y_l_o), 32'd0);
        chk("rst_y_r", 32'(bus.y_r_o), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_o), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_o), 32'd0);
        rst = 1'b0;
        tick();

        // basic frame, N=3, then a back-to-back frame captured in the OUTPUT cycle
        start(16'h1234, 16'hABCD);
        chk("c1_fir_vs", 32'(bus.fir_valid_strobe_o), 32'd1);
        chk("c1_fir_ch", 32'(bus.fir_ch_o), 32'd0);
        chk("c1_fir_sample", 32'(bus.fir_sample_o), 32'h1234);
        chk("c1_busy", 32'(bus.busy_o), 32'd1);
        tick();
        chk("c2_fir_vs", 32'(bus.fir_valid_strobe_o), 32'd0);
        chk("c2_fir_sample", 32'(bus.fir_sample_o), 32'h1234);
        ticks(2);
        respond(24'h001234);
        chk("c5_fir_vs", 32'(bus.fir_valid_strobe_o), 32'd1);
        chk("c5_fir_ch", 32'(bus.fir_ch_o), 32'd1);
        chk("c5_fir_sample", 32'(bus.fir_sample_o), 32'hABCD);
        ticks(3);
        chk("c8_valid", 32'(bus.valid_strobe_o), 32'd0);
        respond(24'h00ABCD);
        chk("c9_valid", 32'(bus.valid_strobe_o), 32'd1);
        chk("c9_y_l", 32'(bus.y_l_o), 32'h001234);
        chk("c9_y_r", 32'(bus.y_r_o), 32'h00ABCD);
        start(16'h0F0F, 16'h7777);
        chk("b2b_valid_off", 32'(bus.valid_strobe_o), 32'd0);
        chk("b2b_fir_vs", 32'(bus.fir_valid_strobe_o), 32'd1);
        chk("b2b_fir_sample", 32'(bus.fir_sample_o), 32'h0F0F);
        chk("b2b_overrun", 32'(bus.overrun_o), 32'd0);
        ticks(3);
        respond(24'h000F0F);
        ticks(3);
        respond(24'h007777);
        chk("b2b_valid", 32'(bus.valid_strobe_o), 32'd1);
        chk("b2b_y_l", 32'(bus.y_l_o), 32'h000F0F);
        chk("b2b_y_r", 32'(bus.y_r_o), 32'h007777);
        tick();
        chk("b2b_idle_valid", 32'(bus.valid_strobe_o), 32'd0);
        chk("b2b_idle_busy", 32'(bus.busy_o), 32'd0);
        chk("hold_y_l", 32'(bus.y_l_o), 32'h000F0F);

        // overrun: strobe in WAIT_L coincident with the L response
        start(16'h1111, 16'h2222);
        ticks(3);
        bus.fir_valid_strobe_i = 1'b1;
        bus.fir_y_i            = 24'h001111;
        bus.valid_strobe_i     = 1'b1;
        bus.sample_l_i         = 16'h5555;
        bus.sample_r_i         = 16'h6666;
        tick();
        bus.fir_valid_strobe_i = 1'b0;
        bus.valid_strobe_i     = 1'b0;
        chk("ovr_flag", 32'(bus.overrun_o), 32'd1);
        chk("ovr_fir_sample", 32'(bus.fir_sample_o), 32'h2222);
        ticks(3);
        respond(24'h002222);
        chk("ovr_valid", 32'(bus.valid_strobe_o), 32'd1);
        chk("ovr_y_l", 32'(bus.y_l_o), 32'h001111);
        chk("ovr_y_r", 32'(bus.y_r_o), 32'h002222);
        tick();
        pulse_clear();
        chk("ovr_cleared", 32'(bus.overrun_o), 32'd0);
        start(16'h3333, 16'h4444);
        bus.valid_strobe_i = 1'b1;
        bus.clear_i        = 1'b1;
        tick();
        bus.valid_strobe_i = 1'b0;
        bus.clear_i        = 1'b0;
        chk("ovr_set_beats_clear", 32'(bus.overrun_o), 32'd1);
        tick();
        respond(24'h003333);
        ticks(3);
        respond(24'h004444);
        chk("ovr2_valid", 32'(bus.valid_strobe_o), 32'd1);
        chk("ovr2_y_r", 32'(bus.y_r_o), 32'h004444);
        tick();
        pulse_clear();

        // timeout on R with TIMEOUT_CYCLES=16
        start(16'h0042, 16'h0099);
        ticks(3);
        respond(24'h000042);
        tick();
        chk("to_c6_ch", 32'(bus.fir_ch_o), 32'd1);
        ticks(15);
        chk("to_c21_valid", 32'(bus.valid_strobe_o), 32'd0);
        chk("to_c21_flag", 32'(bus.timeout_o), 32'd0);
        tick();
        chk("to_c22_valid", 32'(bus.valid_strobe_o), 32'd1);
        chk("to_c22_y_l", 32'(bus.y_l_o), 32'h000042);
        chk("to_c22_y_r", 32'(bus.y_r_o), 32'd0);
        chk("to_c22_flag", 32'(bus.timeout_o), 32'd1);
        tick();
        chk("to_idle_busy", 32'(bus.busy_o), 32'd0);
        pulse_clear();
        chk("to_cleared", 32'(bus.timeout_o), 32'd0);
        start(16'h0042, 16'h0099);
        ticks(3);
        respond(24'h000042);
        ticks(16);
        respond(24'h000099);
        chk("late_valid", 32'(bus.valid_strobe_o), 32'd1);
        chk("late_y_r", 32'(bus.y_r_o), 32'h000099);
        chk("late_flag", 32'(bus.timeout_o), 32'd0);
        tick();

        // reset while in WAIT_R
        start(16'h0101, 16'h0202);
        ticks(3);
        respond(24'h000101);
        ticks(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", 32'(bus.busy_o), 32'd0);
        chk("mrst_fir_vs", 32'(bus.fir_valid_strobe_o), 32'd0);
        chk("mrst_fir_ch", 32'(bus.fir_ch_o), 32'd0);
        chk("mrst_fir_sample", 32'(bus.fir_sample_o), 32'd0);
        chk("mrst_y_l", 32'(bus.y_l_o), 32'd0);
        chk("mrst_y_r", 32'(bus.y_r_o), 32'd0);
        respond(24'h123456);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.valid_strobe_o || bus.busy_o) seen++;
            tick();
        end
        chk("mrst_no_activity", 32'(seen), 32'd0);
        chk("mrst_y_r_kept", 32'(bus.y_r_o), 32'd0);

        // stray FIR strobe in IDLE
        respond(24'h00BEEF);
        chk("stray_busy", 32'(bus.busy_o), 32'd0);
        chk("stray_fir_vs", 32'(bus.fir_valid_strobe_o), 32'd0);
        chk("stray_y_l", 32'(bus.y_l_o), 32'd0);

        frame(16'h0A0A, 16'h0B0B, 1'b0);
        frame(16'h0C0C, 16'h0D0D, 1'b1);
        frame(16'h0E0E, 16'h0F0F, 1'b0);
        chk("stats_overrun", 32'(bus.overrun_o), 32'd1);
`ifdef STUDENT_FIR_SCHED_STATS_EN
        chk("stats_frames", 32'(bus.frame_cnt_o), 32'd3);
        chk("stats_drops", 32'(bus.drop_cnt_o), 32'd1);
        pulse_clear();
        chk("stats_clear_frames", 32'(bus.frame_cnt_o), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
